// File: rtl/i2s_tx_frame_serializer_pkg.sv
// Shared types and helpers for the I2S / left-justified transmit serializer.
package i2s_pkg;

  typedef enum logic {I2S_MODE = 1'b0, LJ_MODE = 1'b1} i2s_mode_t;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} i2s_state_t;

  // Bits needed to hold 0..value-1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/i2s_tx_frame_serializer_sr.sv
// Parallel-in/serial-out shifter, MSB first. When a load and a shift land on
// the same tick, the loaded MSB is presented directly and consumed.
module flex_pts_sr_sync #(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [NUM_BITS-1:0] pdata,
  output logic                sbit
);

  logic [NUM_BITS-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst)                sr <= '0;
    else if (load && shift) sr <= pdata << 1;
    else if (load)          sr <= pdata;
    else if (shift)         sr <= sr << 1;
  end

  assign sbit = load ? pdata[NUM_BITS-1] : sr[NUM_BITS-1];

endmodule

// File: rtl/i2s_tx_frame_serializer.sv
// Stereo I2S / left-justified transmitter: one-pair holding buffer feeding
// left/right shifters, stepped by bit_tick, with frame-boundary control.
module i2s_tx_frame_serializer
  import i2s_pkg::*;
#(
  parameter int        DATA_W       = 24,
  parameter int        SLOT_W       = 32,
  parameter i2s_mode_t MODE_DEFAULT = I2S_MODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              bit_tick,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              in_ready,
  output logic              sdata,
  output logic              ws,
  output logic              frame_start,
  output logic              underrun
);

  localparam int            KW     = clog2(2 * SLOT_W);
  localparam logic [KW-1:0] K_LAST = KW'(2 * SLOT_W - 1);
  localparam logic [KW-1:0] K_SLOT = KW'(SLOT_W);

  i2s_state_t        state, state_n;
  logic [KW-1:0]     k;
  i2s_mode_t         mode_q, mode_eff;
  logic              buf_full, buf_full_n;
  logic [DATA_W-1:0] buf_l, buf_r;
  logic              dly;

  logic              fs, step, stop, move, accept;
  logic              rsel, bit_l, bit_r, b;
  logic [SLOT_W-1:0] ld_l, ld_r;

  // fs: tick that begins a frame; step: tick that emits a bit;
  // stop: frame boundary reached with en low.
  always_comb begin
    state_n = state;
    fs      = 1'b0;
    step    = 1'b0;
    stop    = 1'b0;
    case (state)
      IDLE: begin
        if (bit_tick && en) begin
          state_n = RUN;
          fs      = 1'b1;
          step    = 1'b1;
        end
      end
      RUN: begin
        if (bit_tick) begin
          if (k == '0 && !en) begin
            state_n = IDLE;
            stop    = 1'b1;
          end else begin
            step = 1'b1;
            fs   = (k == '0);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign move     = fs && buf_full;
  assign mode_eff = fs ? i2s_mode_t'(mode) : mode_q;
  assign rsel     = (k >= K_SLOT);

  always_comb begin
    buf_full_n = buf_full;
    if (move)        buf_full_n = 1'b0;
    else if (accept) buf_full_n = 1'b1;
  end

  // Samples sit MSB-aligned in the slot; the tail bits of the slot shift out as 0.
  assign ld_l = move ? (SLOT_W'(buf_l) << (SLOT_W - DATA_W)) : '0;
  assign ld_r = move ? (SLOT_W'(buf_r) << (SLOT_W - DATA_W)) : '0;

  flex_pts_sr_sync #(.NUM_BITS(SLOT_W)) u_sr_left (
    .clk   (clk),
    .rst   (rst),
    .load  (fs),
    .shift (step && !rsel),
    .pdata (ld_l),
    .sbit  (bit_l)
  );

  flex_pts_sr_sync #(.NUM_BITS(SLOT_W)) u_sr_right (
    .clk   (clk),
    .rst   (rst),
    .load  (fs),
    .shift (step && rsel),
    .pdata (ld_r),
    .sbit  (bit_r)
  );

  assign b = rsel ? bit_r : bit_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      mode_q      <= MODE_DEFAULT;
      buf_full    <= 1'b0;
      buf_l       <= '0;
      buf_r       <= '0;
      in_ready    <= 1'b1;
      sdata       <= 1'b0;
      ws          <= 1'b0;
      dly         <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_n;
      frame_start <= fs;
      underrun    <= fs && !buf_full;
      if (fs) mode_q <= mode_eff;
      if (step) begin
        k     <= (k == K_LAST) ? '0 : k + 1'b1;
        ws    <= rsel;
        sdata <= (mode_eff == LJ_MODE) ? b : dly;
        dly   <= b;
      end else if (stop) begin
        // Clearing the delay flop makes the first I2S bit after IDLE a 0.
        k     <= '0;
        ws    <= 1'b0;
        sdata <= 1'b0;
        dly   <= 1'b0;
      end
      if (accept) begin
        buf_l <= in_left;
        buf_r <= in_right;
      end
      buf_full <= buf_full_n;
      in_ready <= !buf_full_n;
    end
  end

endmodule

// File: tb/tb_i2s_tx_frame_serializer.sv
// Scoreboard bench: accepted pairs are queued, each emitted frame is collected
// tick by tick and compared against the queued pair (or zeros on underrun).
module tb_i2s_tx_frame_serializer;
  import i2s_pkg::*;

  localparam int          DW     = 24;
  localparam int          SW     = 32;
  localparam logic [63:0] WS_EXP = {32'hFFFF_FFFF, 32'h0};

  typedef struct packed { logic [DW-1:0] l; logic [DW-1:0] r; } pair_t;

  logic          clk = 0;
  logic          rst = 1;
  logic          en = 0, mode = 1, bit_tick = 0, in_valid = 0;
  logic [DW-1:0] in_left = '0, in_right = '0;
  logic          in_ready, sdata, ws, frame_start, underrun;

  int n_tests = 0, n_fail = 0;

  i2s_tx_frame_serializer #(.DATA_W(DW), .SLOT_W(SW), .MODE_DEFAULT(I2S_MODE)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .bit_tick(bit_tick),
    .in_valid(in_valid), .in_left(in_left), .in_right(in_right),
    .in_ready(in_ready), .sdata(sdata), .ws(ws),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int c;
    c = 0;
    forever begin
      @(posedge clk); #1;
      c = (c == 3) ? 0 : c + 1;
      bit_tick = (c == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_bits(input logic lj, input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < DW; i++) begin
      v[i]      = l[DW-1-i];
      v[SW + i] = r[DW-1-i];
    end
    return lj ? v : (v << 1);
  endfunction

  // Collector / scoreboard
  pair_t       sb[$];
  logic        pre_tick = 0, pre_rst = 1, pre_acc = 0, pre_mode = 0;
  pair_t       pre_pair = '0;
  int          idx = 0, frames_done = 0, extra = 0;
  logic        in_frame = 0, lj_f = 0, exp_un = 0;
  pair_t       cur = '0;
  logic [63:0] obs_d = '0, obs_ws = '0;

  always @(negedge clk) begin
    if (pre_rst) begin
      sb.delete();
      in_frame = 0;
      idx      = 0;
    end else begin
      if (pre_tick) begin
        if (frame_start) begin
          if (in_frame) chk("frame_len", 64'(idx), 64);
          in_frame = 1; idx = 0; extra = 0; lj_f = pre_mode;
          obs_d = '0; obs_ws = '0;
          if (sb.size() > 0) begin cur = sb.pop_front(); exp_un = 0; end
          else begin cur = '0; exp_un = 1; end
          chk("underrun", 64'(underrun), 64'(exp_un));
        end
        if (in_frame) begin
          obs_d[idx]  = sdata;
          obs_ws[idx] = ws;
          if (idx > 0) extra += int'(underrun);
          idx++;
          if (idx == 2 * SW) begin
            chk("frame_data", obs_d, exp_bits(lj_f, cur.l, cur.r));
            chk("frame_ws", obs_ws, WS_EXP);
            chk("mid_underrun", 64'(extra), 0);
            in_frame = 0;
            frames_done++;
          end
        end else begin
          chk("idle_out", 64'({sdata, ws, frame_start, underrun}), 0);
        end
      end else if (frame_start || underrun) begin
        chk("pulse_width", 64'({frame_start, underrun}), 0);
      end
      if (pre_acc) sb.push_back(pre_pair);
    end
    pre_tick = bit_tick;
    pre_rst  = rst;
    pre_acc  = in_valid && in_ready && !rst;
    pre_pair = {in_left, in_right};
    pre_mode = mode;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int t;
    t = 0;
    in_left = l; in_right = r; in_valid = 1;
    while (!in_ready && t < 2000) begin cyc(1); t++; end
    chk("send_ready", 64'(in_ready), 1);
    cyc(1);
    in_valid = 0;
  endtask

  task automatic wait_idx(input int target);
    int t;
    t = 0;
    while (!(in_frame && idx == target) && t < 2000) begin cyc(1); t++; end
    chk("wait_idx", 64'(in_frame && idx == target), 1);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 5000) begin cyc(1); t++; end
    chk("wait_frames", 64'(frames_done >= n), 1);
  endtask

  initial begin
    int fd, t;
    cyc(3);
    chk("rst_ready", 64'(in_ready), 1);
    chk("rst_out", 64'({sdata, ws, frame_start, underrun}), 0);
    rst = 0;
    cyc(2);

    // LJ frame, then I2S frame with the same pair, then underrun, then recovery
    mode = 1;
    send(24'hA5A5A5, 24'h3C3C3C);
    en = 1;
    wait_idx(1);
    mode = 0;
    send(24'hA5A5A5, 24'h3C3C3C);
    wait_frames(2);
    wait_idx(1);
    send(24'h123456, 24'hFEDCBA);
    wait_frames(4);

    // Backpressure: a fresh pair offered every cycle
    in_valid = 1;
    t = 0;
    while (frames_done < 8 && t < 5000) begin
      in_left  = DW'($urandom);
      in_right = DW'($urandom);
      cyc(1);
      t++;
    end
    in_valid = 0;
    chk("bp_frames", 64'(frames_done >= 8), 1);

    // Disable at k=10, mode flip at k=20; buffered pair waits through IDLE
    send(24'h800001, 24'h7FFFFE);
    wait_idx(10);
    en = 0;
    wait_idx(20);
    mode = 1;
    wait_frames(9);
    cyc(40);
    chk("idle_ready", 64'(in_ready), 0);
    chk("idle_pins", 64'({sdata, ws}), 0);
    en = 1;
    wait_idx(1);
    send(24'h0F0F0F, 24'hF0F0F0);

    // Reset at k=40 with the buffer full: held pair must vanish
    wait_idx(40);
    chk("pre_rst_full", 64'(in_ready), 0);
    fd = frames_done;
    rst = 1;
    cyc(1);
    chk("mrst_ready", 64'(in_ready), 1);
    chk("mrst_out", 64'({sdata, ws, frame_start, underrun}), 0);
    rst = 0;
    wait_frames(fd + 1);
    en = 0;
    cyc(600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
